sram_ring_ctrl: RTL and testbench
=================================

# sram_ring_ctrl

Controller that turns the board's external 1M×16 asynchronous SRAM into a circular FIFO between the readout stream (write requester) and the host readout path (read requester). It sits in the top-level FPGA between the readout data stream and the USB bus-side logic, and owns all SRAM pins. It arbitrates the single SRAM port between the two requesters and sequences the CE/OE/WE/byte-enable strobes. It also keeps the FIFO pointers and fill count.

## Interface
- DEPTH, 1048576: FIFO depth in 16-bit words, 2 ≤ DEPTH ≤ 2^20.
- BUS_CLK  in  1  single clock for all logic and SRAM strobes.
- BUS_RST_B  in  1  reset, asynchronous assert, active-low.
- IN_DATA  in  16  write word from the readout stream.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  word accepted when IN_VALID & IN_READY.
- OUT_DATA  out  16  head word to the host.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  host consumes when OUT_VALID & OUT_READY.
- FIFO_COUNT  out  21  words held in SRAM, excluding the output register.
- FIFO_FULL  out  1  FIFO_COUNT == DEPTH.
- FIFO_EMPTY  out  1  FIFO_COUNT == 0 and !OUT_VALID.
- SRAM_A  out  20  address.
- SRAM_IO  inout  16  data; driven only in write states, otherwise high-Z.
- SRAM_BHE_B, SRAM_BLE_B  out  1 each  byte enables, low during any access.
- SRAM_CE1_B, SRAM_OE_B, SRAM_WE_B  out  1 each  chip enable, output enable and write enable, all active-low.

## Operation
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_CAPTURE. The FSM returns to IDLE after every access.
- A read is eligible when !OUT_VALID && FIFO_COUNT > 0.
- A write is eligible when IN_VALID && FIFO_COUNT < DEPTH.
- In IDLE, if only one access is eligible it is granted.
  - If both are eligible, grant the opposite of the last grant (last_grant resets to "write", so the first contested grant goes to read).
  - If neither is eligible, stay in IDLE.
- WR_SETUP: SRAM_A = wr_ptr and CE1_B = 0. SRAM_IO is driven with IN_DATA, which is latched into a write register. IN_READY = 1 in this state only.
- WR_PULSE: WE_B = 0, with address and data held.
- WR_HOLD: WE_B = 1 with address and data still held. At the end of this state, wr_ptr advances and FIFO_COUNT increments.
- RD_ADDR: SRAM_A = rd_ptr, CE1_B = 0, OE_B = 0, SRAM_IO high-Z.
- RD_CAPTURE: OE_B is still 0. At the end of this state, SRAM_IO is registered into OUT_DATA and OUT_VALID is set. rd_ptr advances and FIFO_COUNT decrements.
- OUT_VALID clears when the host consumes the word (OUT_VALID & OUT_READY).
- Pointers wrap from DEPTH-1 to 0; the comparison is against DEPTH, not a power of two.
- FIFO_COUNT changes by at most one per cycle, because only one access is active at a time.
- SRAM_IO is never driven while OE_B = 0.

## Timing
- Reset values:
  - IDLE; both pointers 0; FIFO_COUNT 0; last_grant = write.
  - IN_READY 0; OUT_VALID 0; OUT_DATA 0.
  - SRAM_A 0; CE1_B, OE_B, WE_B, BHE_B and BLE_B all 1; SRAM_IO high-Z.
  - These values apply asynchronously, including mid-access: a WE_B low pulse is aborted and the word is not counted.
- Access length: a write is 4 cycles including IDLE; a read is 3 cycles including IDLE.
- Empty-FIFO write to OUT_VALID: the write is accepted at cycle 0 (WR_SETUP). OUT_VALID rises 5 cycles later, at the end of RD_CAPTURE.
- Full: IN_READY stays 0 while FIFO_COUNT == DEPTH. A read in the same arbitration frees one slot; the next IDLE may then grant the write.
- SRAM setup margin: address and data are stable one full cycle before WE_B falls and one full cycle after WE_B rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the FSM state encoding;
  - SRAM address width (20) and data width (16);
  - the SRAM strobe idle constants.
- One sub-module, sram_ring_ptr: a pointer with wrap at DEPTH, instantiated twice (wr and rd).

## Test plan
- Reset: hold BUS_RST_B low, then release. Required: all strobes 1, SRAM_IO high-Z, FIFO_EMPTY 1, FIFO_COUNT 0.
- Single word: write 0xA5C3. Required: sram[0] = 0xA5C3; OUT_DATA = 0xA5C3 with OUT_VALID 5 cycles after acceptance; FIFO_COUNT back to 0.
- Full with DEPTH = 4 and OUT_READY = 0: push 6 words. Required: 1 word in the output register, FIFO_COUNT = 4, FIFO_FULL = 1, IN_READY held 0.
- Wrap with DEPTH = 4: stream 10 words 0..9 with OUT_READY = 1. Required: output order 0..9 and SRAM_A sequence 0,1,2,3,0,...
- Contention: IN_VALID and OUT_READY held 1 with a non-empty FIFO. Required: read and write grants alternate strictly.
- Reset mid-write: assert BUS_RST_B during WR_PULSE. Required: WE_B goes to 1 immediately, FIFO_COUNT is 0, and the FIFO is empty after release.

Source files
------------

// File: rtl/sram_ring_ctrl_pkg.sv
// Shared types and constants for the SRAM ring-buffer controller:
// FSM encoding, SRAM widths and strobe patterns.
package sram_ring_ctrl_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;
  localparam int CNT_W   = 21;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_SETUP   = 3'd1,
    ST_WR_PULSE   = 3'd2,
    ST_WR_HOLD    = 3'd3,
    ST_RD_ADDR    = 3'd4,
    ST_RD_CAPTURE = 3'd5
  } state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  typedef struct packed {
    logic ce1_b;
    logic oe_b;
    logic we_b;
    logic bhe_b;
    logic ble_b;
  } sram_strobes_t;

  localparam sram_strobes_t SRAM_STROBES_IDLE = '{
    ce1_b: 1'b1, oe_b: 1'b1, we_b: 1'b1, bhe_b: 1'b1, ble_b: 1'b1
  };

  // Chip and both byte lanes are enabled for every access; OE/WE pick the direction.
  function automatic sram_strobes_t access_strobes(input logic rd, input logic we_low);
    sram_strobes_t s;
    s.ce1_b = 1'b0;
    s.bhe_b = 1'b0;
    s.ble_b = 1'b0;
    s.oe_b  = ~rd;
    s.we_b  = ~we_low;
    return s;
  endfunction

endpackage

// File: rtl/sram_ring_ctrl_if.sv
// Stream-side handshake bundle of the ring controller: readout input,
// host output and FIFO status.
interface sram_ring_ctrl_if;
  import sram_ring_ctrl_pkg::*;

  logic [SRAM_DW-1:0] IN_DATA;
  logic               IN_VALID;
  logic               IN_READY;
  logic [SRAM_DW-1:0] OUT_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [CNT_W-1:0]   FIFO_COUNT;
  logic               FIFO_FULL;
  logic               FIFO_EMPTY;

  modport master (
    output IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, FIFO_COUNT, FIFO_FULL, FIFO_EMPTY
  );

  modport slave (
    input  IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, FIFO_COUNT, FIFO_FULL, FIFO_EMPTY
  );

endinterface

// File: rtl/sram_ring_ptr.sv
// Ring pointer that advances by one on request and wraps from DEPTH-1
// back to 0 (DEPTH need not be a power of two).
module sram_ring_ptr
  import sram_ring_ctrl_pkg::*;
#(
  parameter int DEPTH = 1048576
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  output logic [SRAM_AW-1:0] ptr
);

  localparam logic [SRAM_AW-1:0] LAST = SRAM_AW'(DEPTH - 1);

  logic [SRAM_AW-1:0] ptr_q;
  logic [SRAM_AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sram_ring_ctrl.sv
// Circular FIFO on an external asynchronous SRAM: arbitrates one SRAM port
// between the readout stream and the host, and sequences its strobes.
module sram_ring_ctrl
  import sram_ring_ctrl_pkg::*;
#(
  parameter int DEPTH = 1048576
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST_B,
  sram_ring_ctrl_if.slave    bus,
  output logic [SRAM_AW-1:0] SRAM_A,
  inout  wire  [SRAM_DW-1:0] SRAM_IO,
  output logic               SRAM_BHE_B,
  output logic               SRAM_BLE_B,
  output logic               SRAM_CE1_B,
  output logic               SRAM_OE_B,
  output logic               SRAM_WE_B
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRAM_DW-1:0] wr_data_q, wr_data_d;
  logic [SRAM_DW-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  sram_strobes_t      strb_q, strb_d;
  logic               io_drive_q, io_drive_d;

  logic               wr_adv;
  logic               rd_adv;
  logic               rd_elig;
  logic               wr_elig;
  logic [SRAM_AW-1:0] wr_ptr;
  logic [SRAM_AW-1:0] rd_ptr;

  sram_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (BUS_CLK),
    .rst_n (BUS_RST_B),
    .adv   (wr_adv),
    .ptr   (wr_ptr)
  );

  sram_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (BUS_CLK),
    .rst_n (BUS_RST_B),
    .adv   (rd_adv),
    .ptr   (rd_ptr)
  );

  // Arbitration and access sequencing. The write word is latched at grant;
  // the source holds IN_DATA stable until IN_READY, so it is the accepted word.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_data_d    = wr_data_q;
    wr_adv       = 1'b0;
    rd_adv       = 1'b0;
    rd_elig      = !out_valid_q && (cnt_q != '0);
    wr_elig      = bus.IN_VALID && (cnt_q < DEPTH_C);

    case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
          state_d      = ST_WR_SETUP;
          last_grant_d = GRANT_WR;
          wr_data_d    = bus.IN_DATA;
        end else if (rd_elig) begin
          state_d      = ST_RD_ADDR;
          last_grant_d = GRANT_RD;
        end
      end
      ST_WR_SETUP:   state_d = ST_WR_PULSE;
      ST_WR_PULSE:   state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        wr_adv  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_ADDR:    state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        rd_adv  = 1'b1;
        state_d = ST_IDLE;
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  // Fill count, output register and status flags.
  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (wr_adv) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_adv) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (rd_adv) begin
      out_data_d  = SRAM_IO;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end

    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0) && !out_valid_d;
  end

  // SRAM pins are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    strb_d     = SRAM_STROBES_IDLE;
    in_ready_d = 1'b0;
    io_drive_d = 1'b0;
    addr_d     = addr_q;

    case (state_d)
      ST_WR_SETUP: begin
        strb_d     = access_strobes(1'b0, 1'b0);
        in_ready_d = 1'b1;
        io_drive_d = 1'b1;
        addr_d     = wr_ptr;
      end
      ST_WR_PULSE: begin
        strb_d     = access_strobes(1'b0, 1'b1);
        io_drive_d = 1'b1;
        addr_d     = wr_ptr;
      end
      ST_WR_HOLD: begin
        strb_d     = access_strobes(1'b0, 1'b0);
        io_drive_d = 1'b1;
        addr_d     = wr_ptr;
      end
      ST_RD_ADDR, ST_RD_CAPTURE: begin
        strb_d     = access_strobes(1'b1, 1'b0);
        addr_d     = rd_ptr;
      end
      default: begin
        strb_d     = SRAM_STROBES_IDLE;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_WR;
      cnt_q        <= '0;
      wr_data_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      addr_q       <= '0;
      strb_q       <= SRAM_STROBES_IDLE;
      io_drive_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_data_q    <= wr_data_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      addr_q       <= addr_d;
      strb_q       <= strb_d;
      io_drive_q   <= io_drive_d;
    end
  end

  assign SRAM_IO        = io_drive_q ? wr_data_q : 'z;
  assign SRAM_A         = addr_q;
  assign SRAM_CE1_B     = strb_q.ce1_b;
  assign SRAM_OE_B      = strb_q.oe_b;
  assign SRAM_WE_B      = strb_q.we_b;
  assign SRAM_BHE_B     = strb_q.bhe_b;
  assign SRAM_BLE_B     = strb_q.ble_b;

  assign bus.IN_READY   = in_ready_q;
  assign bus.OUT_DATA   = out_data_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.FIFO_COUNT = cnt_q;
  assign bus.FIFO_FULL  = full_q;
  assign bus.FIFO_EMPTY = empty_q;

endmodule

// File: tb/tb_sram_ring_ctrl.sv
// Directed bench for sram_ring_ctrl with DEPTH = 4 and a behavioural
// asynchronous SRAM model on the bidirectional data bus.
module tb_sram_ring_ctrl;

  logic        clk;
  logic        rst_n;
  logic [19:0] sram_a;
  wire  [15:0] sram_io;
  logic        sram_bhe_b, sram_ble_b, sram_ce1_b, sram_oe_b, sram_we_b;

  int n_checks = 0;
  int n_fail   = 0;

  sram_ring_ctrl_if bus();

  sram_ring_ctrl #(.DEPTH(4)) dut (
    .BUS_CLK    (clk),
    .BUS_RST_B  (rst_n),
    .bus        (bus),
    .SRAM_A     (sram_a),
    .SRAM_IO    (sram_io),
    .SRAM_BHE_B (sram_bhe_b),
    .SRAM_BLE_B (sram_ble_b),
    .SRAM_CE1_B (sram_ce1_b),
    .SRAM_OE_B  (sram_oe_b),
    .SRAM_WE_B  (sram_we_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Undriven bus floats to all-ones so a released bus is distinguishable.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (sram_io[gi]);
  end

  logic [15:0] mem [0:1023];
  assign sram_io = (!sram_ce1_b && !sram_oe_b && sram_we_b) ? mem[sram_a[9:0]] : 16'hzzzz;
  always @(posedge sram_we_b) begin
    if (!sram_ce1_b && rst_n) mem[sram_a[9:0]] = sram_io;
  end

  bit          mon_en = 1'b0;
  logic        prev_oe_b = 1'b1;
  bit          grant_log[$];
  logic [19:0] wr_addr_log[$];
  logic [19:0] rd_addr_log[$];
  logic [15:0] out_log[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.IN_READY) begin
        grant_log.push_back(1'b0);
        wr_addr_log.push_back(sram_a);
      end
      if (!sram_oe_b && prev_oe_b) begin
        grant_log.push_back(1'b1);
        rd_addr_log.push_back(sram_a);
      end
      if (bus.OUT_VALID && bus.OUT_READY) out_log.push_back(bus.OUT_DATA);
    end
    prev_oe_b <= sram_oe_b;
  end

  task automatic clear_logs();
    grant_log.delete();
    wr_addr_log.delete();
    rd_addr_log.delete();
    out_log.delete();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 16'h0000;
    bus.OUT_READY = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, output bit ok);
    bus.IN_DATA  = d;
    bus.IN_VALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.IN_READY) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.IN_VALID = 1'b0; bus.IN_DATA = 16'h0; bus.OUT_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sram_ce1_b, sram_oe_b, sram_we_b, sram_bhe_b, sram_ble_b} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 11111",
                         {sram_ce1_b, sram_oe_b, sram_we_b, sram_bhe_b, sram_ble_b});
    end
    n_checks++;
    if (sram_io !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_io_hiz: got %h expected ffff (released)", sram_io);
    end
    n_checks++;
    if (bus.FIFO_EMPTY !== 1'b1 || bus.FIFO_COUNT !== 21'd0 || bus.FIFO_FULL !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: empty %b count %0d full %b expected 1 0 0",
                         bus.FIFO_EMPTY, bus.FIFO_COUNT, bus.FIFO_FULL);
    end
    n_checks++;
    if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 16'h0 || sram_a !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: ready %b ovalid %b odata %h addr %h expected 0 0 0000 00000",
                         bus.IN_READY, bus.OUT_VALID, bus.OUT_DATA, sram_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sram_ce1_b, sram_oe_b, sram_we_b, sram_bhe_b, sram_ble_b} !== 5'b11111 || bus.FIFO_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_idle: strobes %b empty %b expected 11111 1",
                         {sram_ce1_b, sram_oe_b, sram_we_b, sram_bhe_b, sram_ble_b}, bus.FIFO_EMPTY);
    end
  endtask

  task automatic test_single_word();
    bit seen = 1'b0;
    int n = 0;
    do_reset();
    bus.IN_DATA  = 16'hA5C3;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.IN_READY) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: got in_ready %b expected 1 within 20 cycles", seen);
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.OUT_VALID) break;
    end
    n_checks++;
    if (n !== 5 || bus.OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles (valid %b) expected 5", n, bus.OUT_VALID);
    end
    n_checks++;
    if (bus.OUT_DATA !== 16'hA5C3) begin
      n_fail++; $display("FAIL single_data: got %h expected a5c3", bus.OUT_DATA);
    end
    n_checks++;
    if (mem[0] !== 16'hA5C3) begin
      n_fail++; $display("FAIL single_sram0: got %h expected a5c3", mem[0]);
    end
    n_checks++;
    if (bus.FIFO_COUNT !== 21'd0 || bus.FIFO_EMPTY !== 1'b0) begin
      n_fail++; $display("FAIL single_count: count %0d empty %b expected 0 0", bus.FIFO_COUNT, bus.FIFO_EMPTY);
    end
    bus.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b0;
    n_checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.FIFO_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL single_consume: valid %b empty %b expected 0 1", bus.OUT_VALID, bus.FIFO_EMPTY);
    end
  endtask

  task automatic test_full();
    bit ok;
    int push_fail = 0;
    bit ready_seen = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'h0100 + 16'(i), ok);
      if (!ok) push_fail++;
    end
    n_checks++;
    if (push_fail !== 0) begin
      n_fail++; $display("FAIL full_push: got %0d timed-out pushes expected 0", push_fail);
    end
    bus.IN_DATA  = 16'h0105;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.IN_READY) ready_seen = 1'b1;
    end
    n_checks++;
    if (ready_seen !== 1'b0) begin
      n_fail++; $display("FAIL full_in_ready: got %b expected held 0", ready_seen);
    end
    n_checks++;
    if (bus.FIFO_COUNT !== 21'd4 || bus.FIFO_FULL !== 1'b1 || bus.FIFO_EMPTY !== 1'b0) begin
      n_fail++; $display("FAIL full_status: count %0d full %b empty %b expected 4 1 0",
                         bus.FIFO_COUNT, bus.FIFO_FULL, bus.FIFO_EMPTY);
    end
    n_checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 16'h0100) begin
      n_fail++; $display("FAIL full_outreg: valid %b data %h expected 1 0100", bus.OUT_VALID, bus.OUT_DATA);
    end
    // Draining one word must let the waiting sixth word in.
    clear_logs();
    mon_en = 1'b1;
    bus.OUT_READY = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.IN_READY) begin
        ready_seen = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    bus.IN_VALID = 1'b0;
    n_checks++;
    if (ready_seen !== 1'b1) begin
      n_fail++; $display("FAIL full_reaccept: got %b expected 1 after drain", ready_seen);
    end
    for (int i = 0; i < 200 && out_log.size() < 6; i++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    bus.OUT_READY = 1'b0;
    n_checks++;
    if (out_log.size() !== 6) begin
      n_fail++; $display("FAIL full_drain_count: got %0d words expected 6", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 6; i++) begin
      n_checks++;
      if (out_log[i] !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL full_drain_data[%0d]: got %h expected %h", i, out_log[i], 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int push_fail = 0;
    do_reset();
    clear_logs();
    mon_en = 1'b1;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(16'(i), ok);
      if (!ok) push_fail++;
    end
    for (int i = 0; i < 300 && out_log.size() < 10; i++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    bus.OUT_READY = 1'b0;
    n_checks++;
    if (push_fail !== 0 || out_log.size() !== 10) begin
      n_fail++; $display("FAIL wrap_count: timeouts %0d words %0d expected 0 10", push_fail, out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 10; i++) begin
      n_checks++;
      if (out_log[i] !== 16'(i)) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, out_log[i], 16'(i));
      end
    end
    for (int i = 0; i < wr_addr_log.size() && i < 10; i++) begin
      n_checks++;
      if (wr_addr_log[i] !== 20'(i % 4)) begin
        n_fail++; $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wr_addr_log[i], i % 4);
      end
    end
    for (int i = 0; i < rd_addr_log.size() && i < 10; i++) begin
      n_checks++;
      if (rd_addr_log[i] !== 20'(i % 4)) begin
        n_fail++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, rd_addr_log[i], i % 4);
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    int push_fail = 0;
    int n_grants;
    int alt_bad = 0;
    bit primed = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(16'h0200 + 16'(i), ok);
      if (!ok) push_fail++;
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.OUT_VALID && bus.FIFO_COUNT == 21'd2) begin primed = 1'b1; break; end
    end
    n_checks++;
    if (push_fail !== 0 || primed !== 1'b1) begin
      n_fail++; $display("FAIL contend_prime: timeouts %0d primed %b expected 0 1", push_fail, primed);
    end
    clear_logs();
    mon_en = 1'b1;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(16'h0203 + 16'(i), ok);
      if (!ok) push_fail++;
    end
    n_grants = grant_log.size();
    // Held requests: W R W R ... W, eight writes with seven reads between.
    n_checks++;
    if (n_grants !== 15 || grant_log[0] !== 1'b0) begin
      n_fail++; $display("FAIL contend_grants: got %0d grants (first %b) expected 15 starting with write",
                         n_grants, grant_log[0]);
    end
    for (int i = 1; i < n_grants; i++) begin
      if (grant_log[i] === grant_log[i-1]) alt_bad++;
    end
    n_checks++;
    if (alt_bad !== 0) begin
      n_fail++; $display("FAIL contend_alternate: got %0d repeated grants expected 0", alt_bad);
    end
    for (int i = 0; i < 300 && out_log.size() < 11; i++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    bus.OUT_READY = 1'b0;
    n_checks++;
    if (out_log.size() !== 11) begin
      n_fail++; $display("FAIL contend_out_count: got %0d words expected 11", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 11; i++) begin
      n_checks++;
      if (out_log[i] !== 16'h0200 + 16'(i)) begin
        n_fail++; $display("FAIL contend_data[%0d]: got %h expected %h", i, out_log[i], 16'h0200 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    do_reset();
    bus.IN_DATA  = 16'h3C3C;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (sram_we_b === 1'b0) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL midwr_pulse: got we_b low %b expected 1", seen);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sram_we_b !== 1'b1 || sram_ce1_b !== 1'b1) begin
      n_fail++; $display("FAIL midwr_abort: we_b %b ce1_b %b expected 1 1", sram_we_b, sram_ce1_b);
    end
    n_checks++;
    if (bus.FIFO_COUNT !== 21'd0 || sram_io !== 16'hFFFF) begin
      n_fail++; $display("FAIL midwr_state: count %0d io %h expected 0 ffff", bus.FIFO_COUNT, sram_io);
    end
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bus.FIFO_EMPTY !== 1'b1 || bus.FIFO_COUNT !== 21'd0 || bus.OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL midwr_after: empty %b count %0d ovalid %b expected 1 0 0",
                         bus.FIFO_EMPTY, bus.FIFO_COUNT, bus.OUT_VALID);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full();
    test_wrap();
    test_contention();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
